mont_mul_param: RTL and testbench

//  Parametrised radix-2 Montgomery multiplier coprocessor: computes A*B*2^(-32*NWORDS) mod N for NWORDS-word operands.

---
 rtl/mont_mul_pkg.sv | 22 ++
 rtl/mont_mul_if.sv | 24 ++
 rtl/mont_mul_dp.sv | 62 ++++++
 rtl/mont_mul_param.sv | 226 ++++++++++++++++++++++
 tb/tb_mont_mul_param.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_mul_pkg.sv
// Shared encodings for the Montgomery multiplier coprocessor: FSM states,
// operand fetch phases and the LSU access type.
package mont_mul_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ADD_B,
      S_ADD_N,
      S_REDUCE,
      S_WRITE
   } state_e;

   typedef enum logic [1:0] {
      PH_A,
      PH_B,
      PH_N
   } phase_e;

   localparam logic [1:0] LSU_DATA_WORD = 2'b10;

endpackage

// File: rtl/mont_mul_if.sv
// LSU request/response port shared between the core and the coprocessor;
// master issues requests, slave answers with lsu_done/lsu_rdata.
interface mont_mul_if;

   logic        lsu_ren;
   logic        lsu_wen;
   logic [1:0]  lsu_type;
   logic [31:0] lsu_addr_base;
   logic [31:0] lsu_addr_offset;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic [31:0] lsu_wdata;

   modport master (
      output lsu_ren, lsu_wen, lsu_type, lsu_addr_base, lsu_addr_offset, lsu_wdata,
      input  lsu_done, lsu_rdata
   );

   modport slave (
      input  lsu_ren, lsu_wen, lsu_type, lsu_addr_base, lsu_addr_offset, lsu_wdata,
      output lsu_done, lsu_rdata
   );

endinterface

// File: rtl/mont_mul_dp.sv
// Montgomery accumulator: (W+2)-bit M register around one shared
// adder/subtractor, used for +B, +N with shift, and the final M-N.
module mont_mul_dp #(
   parameter int unsigned W = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         add_b_i,
   input  logic         add_n_i,
   input  logic         reduce_i,
   input  logic         a0_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] n_i,
   output logic [W-1:0] m_o
);

   localparam int unsigned MW = W + 2;

   logic [MW-1:0] m_q, m_d, opnd;
   logic          cin;
   logic [MW:0]   sum;
   logic          ge_n;

   always_comb begin
      opnd = '0;
      cin  = 1'b0;
      if (add_b_i) begin
         opnd = {2'b00, b_i};
      end else if (add_n_i) begin
         opnd = {2'b00, n_i};
      end else if (reduce_i) begin
         opnd = ~{2'b00, n_i};
         cin  = 1'b1;
      end
   end

   assign sum  = {1'b0, m_q} + {1'b0, opnd} + {{MW{1'b0}}, cin};
   // Carry out of M + ~N + 1 is set exactly when M >= N.
   assign ge_n = sum[MW];

   always_comb begin
      m_d = m_q;
      if (clr_i) begin
         m_d = '0;
      end else if (add_b_i) begin
         if (a0_i) m_d = sum[MW-1:0];
      end else if (add_n_i) begin
         m_d = m_q[0] ? (sum[MW-1:0] >> 1) : (m_q >> 1);
      end else if (reduce_i && ge_n) begin
         m_d = sum[MW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_q <= '0;
      else        m_q <= m_d;
   end

   assign m_o = m_q[W-1:0];

endmodule

// File: rtl/mont_mul_param.sv
// Radix-2 Montgomery multiplier coprocessor: fetch A/B/N over the LSU, run the
// bit-serial loop, write back A*B*2^-W mod N. Optional abort port: MONT_MUL_ABORT_EN.
module mont_mul_param
   import mont_mul_pkg::*;
#(
   parameter int unsigned NWORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [31:0]           A_addr,
   input  logic [31:0]           B_addr,
   input  logic [31:0]           N_addr,
   input  logic [31:0]           res_addr,
`ifdef MONT_MUL_ABORT_EN
   input  logic                  abort,
`endif
   mont_mul_if.master            lsu,
   output logic [32*NWORDS-1:0]  result,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned W  = 32 * NWORDS;
   localparam int unsigned IW = $clog2(NWORDS) + 1;
   localparam int unsigned CW = $clog2(W) + 1;

   state_e        state_q, state_d;
   phase_e        phase_q, phase_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, n_q, n_d;
   logic [31:0]   a_base_q, a_base_d, b_base_q, b_base_d;
   logic [31:0]   n_base_q, n_base_d, r_base_q, r_base_d;
   logic          mode_q, mode_d;
   logic          done_q, done_d;

   logic          dp_clr, dp_add_b, dp_add_n, dp_reduce;
   logic [W-1:0]  m;
   logic          ren_w, wen_w;
   logic [31:0]   base_w, offset_w, wdata_w;
   logic          last_word;
   logic          abort_w;

`ifdef MONT_MUL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign last_word = (idx_q == IW'(NWORDS - 1));

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      n_d      = n_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      n_base_d = n_base_q;
      r_base_d = r_base_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      dp_clr    = 1'b0;
      dp_add_b  = 1'b0;
      dp_add_n  = 1'b0;
      dp_reduce = 1'b0;
      ren_w    = 1'b0;
      wen_w    = 1'b0;
      base_w   = '0;
      offset_w = '0;
      offset_w[IW+1:0] = {idx_q, 2'b00};
      wdata_w  = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_base_d = A_addr;
               b_base_d = B_addr;
               n_base_d = N_addr;
               r_base_d = res_addr;
               mode_d   = mode;
               dp_clr   = 1'b1;
               cnt_d    = '0;
               idx_d    = '0;
               phase_d  = PH_A;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            ren_w = 1'b1;
            unique case (phase_q)
               PH_A:    base_w = a_base_q;
               PH_B:    base_w = b_base_q;
               default: base_w = n_base_q;
            endcase
            if (lsu.lsu_done) begin
               unique case (phase_q)
                  PH_A:    a_d[{idx_q, 5'b00000} +: 32] = lsu.lsu_rdata;
                  PH_B:    b_d[{idx_q, 5'b00000} +: 32] = lsu.lsu_rdata;
                  default: n_d[{idx_q, 5'b00000} +: 32] = lsu.lsu_rdata;
               endcase
               if (last_word) begin
                  idx_d = '0;
                  unique case (phase_q)
                     PH_A:    phase_d = mode_q ? PH_N : PH_B;
                     PH_B:    phase_d = PH_N;
                     default: begin
                        state_d = S_ADD_B;
                        cnt_d   = '0;
                        if (mode_q) b_d = a_q;
                     end
                  endcase
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_ADD_B: begin
            dp_add_b = 1'b1;
            state_d  = S_ADD_N;
         end
         S_ADD_N: begin
            dp_add_n = 1'b1;
            a_d      = a_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            state_d  = (cnt_q == CW'(W - 1)) ? S_REDUCE : S_ADD_B;
         end
         S_REDUCE: begin
            dp_reduce = 1'b1;
            idx_d     = '0;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            wen_w   = 1'b1;
            base_w  = r_base_q;
            wdata_w = m[{idx_q, 5'b00000} +: 32];
            if (lsu.lsu_done) begin
               if (last_word) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything: drop the request now, freeze M, no done.
      if (abort_w && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         idx_d     = '0;
         done_d    = 1'b0;
         ren_w     = 1'b0;
         wen_w     = 1'b0;
         dp_add_b  = 1'b0;
         dp_add_n  = 1'b0;
         dp_reduce = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         phase_q  <= PH_A;
         idx_q    <= '0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         n_q      <= '0;
         a_base_q <= '0;
         b_base_q <= '0;
         n_base_q <= '0;
         r_base_q <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         n_q      <= n_d;
         a_base_q <= a_base_d;
         b_base_q <= b_base_d;
         n_base_q <= n_base_d;
         r_base_q <= r_base_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
      end
   end

   mont_mul_dp #(
      .W (W)
   ) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (dp_clr),
      .add_b_i  (dp_add_b),
      .add_n_i  (dp_add_n),
      .reduce_i (dp_reduce),
      .a0_i     (a_q[0]),
      .b_i      (b_q),
      .n_i      (n_q),
      .m_o      (m)
   );

   assign lsu.lsu_ren         = ren_w;
   assign lsu.lsu_wen         = wen_w;
   assign lsu.lsu_type        = LSU_DATA_WORD;
   assign lsu.lsu_addr_base   = base_w;
   assign lsu.lsu_addr_offset = offset_w;
   assign lsu.lsu_wdata       = wdata_w;

   assign result = m;
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;

endmodule

// File: tb/tb_mont_mul_param.sv
// Bench for mont_mul_param: NWORDS=1 and NWORDS=4 instances share one
// random-latency LSU model; results checked against a modular-arithmetic reference.
module tb_mont_mul_param;
   import mont_mul_pkg::*;

   localparam logic [31:0] A_BASE = 32'h0000_1000;
   localparam logic [31:0] B_BASE = 32'h0000_2000;
   localparam logic [31:0] N_BASE = 32'h0000_3000;
   localparam logic [31:0] R_BASE = 32'h0000_4000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0, start4 = 1'b0, mode_r = 1'b0;
   logic sel = 1'b0, spur = 1'b0;
`ifdef MONT_MUL_ABORT_EN
   logic abort = 1'b0;
`endif
   logic [31:0]  res1;
   logic [127:0] res4;
   logic busy1, busy4, done1, done4;

   always #5 clk = ~clk;

   mont_mul_if bus1 ();
   mont_mul_if bus4 ();

   mont_mul_param #(.NWORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode_r),
      .A_addr(A_BASE), .B_addr(B_BASE), .N_addr(N_BASE), .res_addr(R_BASE),
`ifdef MONT_MUL_ABORT_EN
      .abort(abort),
`endif
      .lsu(bus1), .result(res1), .busy(busy1), .done(done1));

   mont_mul_param #(.NWORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode_r),
      .A_addr(A_BASE), .B_addr(B_BASE), .N_addr(N_BASE), .res_addr(R_BASE),
`ifdef MONT_MUL_ABORT_EN
      .abort(abort),
`endif
      .lsu(bus4), .result(res4), .busy(busy4), .done(done4));

   // Request mux towards the single LSU model.
   logic        rq_ren, rq_wen, busy_s, done_s;
   logic [1:0]  rq_type;
   logic [31:0] rq_base, rq_off, rq_wdata, rq_ad;
   logic [127:0] res_s;
   logic [97:0] req_vec, p_vec;
   logic        r_done = 1'b0;
   logic [31:0] r_data = '0;

   assign rq_ren   = sel ? bus4.lsu_ren : bus1.lsu_ren;
   assign rq_wen   = sel ? bus4.lsu_wen : bus1.lsu_wen;
   assign rq_type  = sel ? bus4.lsu_type : bus1.lsu_type;
   assign rq_base  = sel ? bus4.lsu_addr_base : bus1.lsu_addr_base;
   assign rq_off   = sel ? bus4.lsu_addr_offset : bus1.lsu_addr_offset;
   assign rq_wdata = sel ? bus4.lsu_wdata : bus1.lsu_wdata;
   assign rq_ad    = rq_base + rq_off;
   assign busy_s   = sel ? busy4 : busy1;
   assign done_s   = sel ? done4 : done1;
   assign res_s    = sel ? res4 : {96'b0, res1};
   assign req_vec  = {rq_ren, rq_wen, rq_base, rq_off, rq_wdata};
   assign bus1.lsu_done  = !sel && (r_done || spur);
   assign bus4.lsu_done  = sel && (r_done || spur);
   assign bus1.lsu_rdata = r_data;
   assign bus4.lsu_rdata = r_data;

   logic [31:0] mem [logic [31:0]];
   int unsigned wait_c = 0, lim = 0;
   int n_reads = 0, n_breads = 0, n_wr = 0, stab_err = 0, type_err = 0, lc = 0, dn_cnt = 0;
   logic [31:0] wr_off [64];
   logic [31:0] wr_base [64];
   logic [31:0] wr_data [64];

   always @(posedge clk) begin
      r_done <= 1'b0;
      p_vec  <= req_vec;
      if (busy_s && !rq_ren && !rq_wen) lc <= lc + 1;
      if (done_s) dn_cnt <= dn_cnt + 1;
      if ((rq_ren || rq_wen) && !r_done) begin
         if (wait_c != 0 && req_vec != p_vec) stab_err <= stab_err + 1;
         if (rq_type != LSU_DATA_WORD) type_err <= type_err + 1;
         if (wait_c >= lim) begin
            r_done <= 1'b1;
            wait_c <= 0;
            lim    <= $urandom_range(0, 5);
            if (rq_ren) begin
               r_data  <= mem.exists(rq_ad) ? mem[rq_ad] : 32'h0;
               n_reads <= n_reads + 1;
               if (rq_base == B_BASE) n_breads <= n_breads + 1;
            end else begin
               wr_off[n_wr % 64]  <= rq_off;
               wr_base[n_wr % 64] <= rq_base;
               wr_data[n_wr % 64] <= rq_wdata;
               n_wr <= n_wr + 1;
            end
         end else begin
            wait_c <= wait_c + 1;
         end
      end else if (!(rq_ren || rq_wen)) begin
         wait_c <= 0;
      end
   end

   int n_cmp = 0, n_err = 0;
   logic [127:0] sb_q [$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: (A*B mod N) halved modulo N once per operand bit.
   function automatic logic [127:0] mont_ref(input logic [127:0] a, input logic [127:0] b,
                                             input logic [127:0] n, input int unsigned w);
      logic [259:0] p, nn;
      nn = {132'b0, n};
      p  = ({132'b0, a} * {132'b0, b}) % nn;
      for (int unsigned i = 0; i < w; i++) p = p[0] ? ((p + nn) >> 1) : (p >> 1);
      return p[127:0];
   endfunction

   typedef struct {
      logic         sel;
      logic         mode;
      logic [127:0] a, b, n, exp;
      logic         stress;
   } vec_t;

   vec_t vt [10];

   task automatic set_start(input logic v);
      if (sel) start4 = v; else start1 = v;
   endtask

   task automatic load_mem(input vec_t v);
      int unsigned nw;
      nw = v.sel ? 4 : 1;
      sel = v.sel;
      for (int unsigned k = 0; k < nw; k++) begin
         mem[A_BASE + 4 * k] = v.a[32 * k +: 32];
         mem[B_BASE + 4 * k] = v.mode ? $urandom : v.b[32 * k +: 32];
         mem[N_BASE + 4 * k] = v.n[32 * k +: 32];
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int unsigned nw, w;
      int s_rd, s_brd, s_wr, s_stab, s_type, s_lc, s_dn;
      logic got;
      logic [127:0] e;
      nw = v.sel ? 4 : 1;
      w  = 32 * nw;
      load_mem(v);
      @(posedge clk); #1 spur = 1'b1;
      @(posedge clk); #1 spur = 1'b0;
      chk($sformatf("v%0d_spurious_idle", idx), busy_s, 1'b0);
      s_rd = n_reads; s_brd = n_breads; s_wr = n_wr; s_stab = stab_err;
      s_type = type_err; s_lc = lc; s_dn = dn_cnt;
      mode_r = v.mode;
      set_start(1'b1);
      sb_q.push_back(v.exp);
      @(posedge clk); #1 set_start(1'b0);
      chk($sformatf("v%0d_busy", idx), busy_s, 1'b1);
      got = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         if (v.stress && c == 30) begin
            mode_r = ~v.mode;
            set_start(1'b1);
         end else begin
            set_start(1'b0);
         end
         if (done_s) begin
            got = 1'b1;
            break;
         end
      end
      set_start(1'b0);
      mode_r = v.mode;
      chk($sformatf("v%0d_done_seen", idx), got, 1'b1);
      e = sb_q.pop_front();
      chk($sformatf("v%0d_result", idx), res_s, e);
      chk($sformatf("v%0d_reads", idx), n_reads - s_rd, nw * (v.mode ? 2 : 3));
      chk($sformatf("v%0d_b_reads", idx), n_breads - s_brd, v.mode ? 0 : nw);
      chk($sformatf("v%0d_writes", idx), n_wr - s_wr, nw);
      for (int unsigned k = 0; k < nw; k++) begin
         chk($sformatf("v%0d_wr%0d", idx, k),
             {wr_base[(s_wr + k) % 64], wr_off[(s_wr + k) % 64], wr_data[(s_wr + k) % 64]},
             {R_BASE, 32'(4 * k), e[32 * k +: 32]});
      end
      chk($sformatf("v%0d_loop_cycles", idx), lc - s_lc, 2 * w + 1);
      chk($sformatf("v%0d_addr_stable", idx), stab_err - s_stab, 0);
      chk($sformatf("v%0d_lsu_type", idx), type_err - s_type, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", idx), {done_s, 32'(dn_cnt - s_dn)}, {1'b0, 32'd1});
   endtask

   initial begin
      logic [127:0] r;
      int s_dn;
      logic got;

      vt[0] = '{1'b0, 1'b0, 128'd3, 128'd5, 128'd7, 128'd2, 1'b0};
      vt[1] = '{1'b0, 1'b1, 128'd3, 128'd0, 128'd7, 128'd4, 1'b1};
      vt[2] = '{1'b1, 1'b0, 128'd1, 128'd1, {128{1'b1}}, 128'd1, 1'b0};
      vt[3] = '{1'b1, 1'b0, 128'd0, {{127{1'b1}}, 1'b0}, {128{1'b1}}, 128'd0, 1'b1};
      vt[4] = '{1'b0, 1'b0, 128'hFFFF_FFFE, 128'hFFFF_FFFE, 128'hFFFF_FFFF, 128'd1, 1'b0};
      for (int unsigned i = 5; i < 10; i++) begin
         vt[i].sel    = (i >= 7);
         vt[i].mode   = (i % 2 == 0);
         vt[i].stress = (i % 3 == 0);
         r = vt[i].sel ? {$urandom, $urandom, $urandom, $urandom} : {96'b0, $urandom};
         vt[i].n = r | (vt[i].sel ? {1'b1, 126'b0, 1'b1} : {96'b0, 32'h8000_0001});
         r = vt[i].sel ? {$urandom, $urandom, $urandom, $urandom} : {96'b0, $urandom};
         vt[i].a = r % vt[i].n;
         r = vt[i].sel ? {$urandom, $urandom, $urandom, $urandom} : {96'b0, $urandom};
         vt[i].b = vt[i].mode ? vt[i].a : r % vt[i].n;
         vt[i].exp = mont_ref(vt[i].a, vt[i].b, vt[i].n, vt[i].sel ? 128 : 32);
      end

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {busy1, busy4, done1, done4, bus1.lsu_ren, bus1.lsu_wen,
                            bus4.lsu_ren, bus4.lsu_wen}, 8'h00);
      chk("reset_result", {res4, res1}, '0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vt[i], i);

      // Reset in the middle of the loop, then a clean rerun.
      load_mem(vt[7]);
      s_dn = dn_cnt;
      mode_r = vt[7].mode;
      set_start(1'b1);
      sb_q.push_back(vt[7].exp);
      @(posedge clk); #1 set_start(1'b0);
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         if (dut4.state_q == S_ADD_N && dut4.cnt_q == 8'd40) begin
            got = 1'b1;
            break;
         end
      end
      chk("rst_reach_add_n", got, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", {busy4, done4, bus4.lsu_ren, bus4.lsu_wen}, 4'h0);
      r = sb_q.pop_front();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_result_cleared", res4, '0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_done", dn_cnt - s_dn, 0);
      run_vec(vt[7], 20);

`ifdef MONT_MUL_ABORT_EN
      // Start wins over a simultaneous abort; a later abort in FETCH returns to IDLE.
      load_mem(vt[8]);
      s_dn = dn_cnt;
      mode_r = vt[8].mode;
      abort = 1'b1;
      set_start(1'b1);
      sb_q.push_back(vt[8].exp);
      @(posedge clk); #1;
      set_start(1'b0);
      abort = 1'b0;
      chk("abort_start_wins", busy4, 1'b1);
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (bus4.lsu_ren && c > 3) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("abort_in_fetch", got, 1'b1);
      abort = 1'b1;
      #1;
      chk("abort_drops_req", {bus4.lsu_ren, bus4.lsu_wen}, 2'b00);
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_idle", busy4, 1'b0);
      r = sb_q.pop_front();
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", dn_cnt - s_dn, 0);
      run_vec(vt[8], 21);
`endif

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
